vote_report_tx: RTL

Serial results transmitter for the voting machine. On a start request it snapshots the four 8-bit candidate tallies and sends them LSB-first as a framed burst of 8N1 UART bytes on a single `tx` line, so a host can read results without stepping through the DIP-switch display. It sits beside the vote-counting logic, takes the per-candidate press counters as inputs, and drives a board UART pin.

---
 rtl/vote_report_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vote_report_tx.sv
// Serial results transmitter: snapshots four 8-bit tallies and sends a framed 8N1 UART burst.
// Optional trailing checksum byte enabled by defining VOTE_REPORT_CHECKSUM_EN.
module vote_report_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tally_1,
  input  logic [7:0] tally_2,
  input  logic [7:0] tally_3,
  input  logic [7:0] tally_4,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef VOTE_REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  state_t      state_q, state_d;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_idx;
  logic [7:0]  data_byte;
  logic [7:0]  next_byte;
  logic [7:0]  snap_1, snap_2, snap_3, snap_4;
  logic        tx_d, busy_d;
  logic        tx_q, busy_q, done_q;
  logic        baud_tick, last_byte, accept;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign last_byte = (byte_idx == LAST_BYTE);
  // busy_q still high in the first IDLE cycle, so a start there is ignored.
  assign accept    = (state_q == IDLE) && start && !busy_q;

`ifdef VOTE_REPORT_CHECKSUM_EN
  logic [7:0] checksum;
  assign checksum = snap_1 + snap_2 + snap_3 + snap_4;
`endif

  // Byte that follows the one at byte_idx in the frame.
  always_comb begin
    // NOTE: default assignment first so no path leaves next_byte unassigned (no latch).
    next_byte = 8'h00;
    case (byte_idx)
      3'd0:    next_byte = snap_1;
      3'd1:    next_byte = snap_2;
      3'd2:    next_byte = snap_3;
      3'd3:    next_byte = snap_4;
`ifdef VOTE_REPORT_CHECKSUM_EN
      3'd4:    next_byte = checksum;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = START_BIT;
      START_BIT: if (baud_tick) state_d = DATA;
      DATA:      if (baud_tick && bit_cnt == 3'd7) state_d = STOP_BIT;
      STOP_BIT:  if (baud_tick) state_d = last_byte ? IDLE : START_BIT;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    case (state_q)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = data_byte[bit_cnt];
      default:   tx_d = 1'b1;
    endcase
  end

  // Datapath: counters, snapshot and current byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      data_byte <= '0;
      snap_1    <= '0;
      snap_2    <= '0;
      snap_3    <= '0;
      snap_4    <= '0;
    end else if (state_q == IDLE) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      if (accept) begin
        snap_1    <= tally_1;
        snap_2    <= tally_2;
        snap_3    <= tally_3;
        snap_4    <= tally_4;
        byte_idx  <= '0;
        data_byte <= HEADER;
      end
    end else begin
      baud_cnt <= baud_tick ? 16'd0 : baud_cnt + 16'd1;
      if (state_q == DATA && baud_tick)
        bit_cnt <= bit_cnt + 3'd1;
      if (state_q == STOP_BIT && baud_tick && !last_byte) begin
        byte_idx  <= byte_idx + 3'd1;
        data_byte <= next_byte;
      end
    end
  end

  // Registered outputs: one cycle behind the FSM, glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= busy_q && !busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
